fft_out_reorder: RTL and testbench

- Output-side consumer for the 32-point radix-2 MDC FFT pipeline; sits after the last butterfly stage.
- Accepts the two-lane (upper/lower) bit-reversed result stream, 2 samples/beat, 16 beats/frame.
- Buffers each frame in a ping-pong store and emits one complex sample per cycle in natural order (X[0]..X[31]), with valid/ready handshakes on both sides.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_reorder_bank.sv | 48 ++++
 rtl/fft_out_reorder.sv | 167 ++++++++++++++++
 tb/tb_fft_out_reorder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helpers for the 32-point FFT output path.
package fft_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int N         = 32;
  localparam int LOG2N     = 5;

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } cplx_t;

  // Reverse the four bits of a beat index.
  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame store: 32 complex entries, two write ports sharing one enable
// (upper/lower lane of a beat), one combinational read port.
// Storage carries no reset; validity is tracked by the owner's full flags.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] up_addr,
  input  logic [WIDTH-1:0] up_re,
  input  logic [WIDTH-1:0] up_im,
  input  logic [LOG2N-1:0] lo_addr,
  input  logic [WIDTH-1:0] lo_re,
  input  logic [WIDTH-1:0] lo_im,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_re,
  output logic [WIDTH-1:0] rd_im
);

  logic [WIDTH-1:0] re_q [N];
  logic [WIDTH-1:0] im_q [N];
  logic [WIDTH-1:0] re_d [N];
  logic [WIDTH-1:0] im_d [N];

  // Next-state of the array: both lanes of a beat land in the same cycle.
  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (we) begin
      re_d[up_addr] = up_re;
      im_d[up_addr] = up_im;
      re_d[lo_addr] = lo_re;
      im_d[lo_addr] = lo_im;
    end
  end

  // Array storage.
  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  assign rd_re = re_q[rd_addr];
  assign rd_im = im_q[rd_addr];

endmodule

// File: rtl/fft_out_reorder.sv
// Natural-order reorder buffer after the last MDC butterfly stage.
// Ping-pong pair of banks: write two bit-reversed samples per beat, read one
// natural-order sample per cycle into a registered output stage.
// Optional build macro FFT_OUT_REORDER_SOP_EN adds in_sop realignment and a
// sticky frame_err flag.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_up_re,
  input  logic [WIDTH-1:0] in_up_im,
  input  logic [WIDTH-1:0] in_l_re,
  input  logic [WIDTH-1:0] in_l_im,
`ifdef FFT_OUT_REORDER_SOP_EN
  input  logic             in_sop,
  output logic             frame_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic [4:0]       out_index,
  output logic             out_last
);

  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [1:0]       full_q, full_d;
  logic [3:0]       k_q, k_d;
  logic [4:0]       ridx_q, ridx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;
  logic [4:0]       out_index_q, out_index_d;
  logic             out_last_q, out_last_d;
  logic             frame_err_q, frame_err_d;

  logic             accept, realign, last_beat, readable, load;
  logic [3:0]       keff;
  logic [3:0]       brk;
  logic [WIDTH-1:0] b0_re, b0_im, b1_re, b1_im, rd_re, rd_im;

  assign in_ready = ~full_q[wbank_q];
  assign accept   = in_valid && in_ready;

`ifdef FFT_OUT_REORDER_SOP_EN
  assign realign = accept && in_sop && (k_q != 4'd0);
`else
  assign realign = 1'b0;
`endif

  // A realigning beat is written as beat 0 of the same bank.
  assign keff      = realign ? 4'd0 : k_q;
  assign brk       = bitrev4(keff);
  assign last_beat = accept && (keff == 4'd15);

  // X[0] comes from beat 0, so the read side may start on the edge that
  // completes the frame, before the full flag is visible.
  assign readable = full_q[rbank_q] || (last_beat && (wbank_q == rbank_q));
  assign load     = readable && (!out_valid_q || out_ready);

  assign rd_re = rbank_q ? b1_re : b0_re;
  assign rd_im = rbank_q ? b1_im : b0_im;

  fft_reorder_bank #(.WIDTH(WIDTH)) u_bank0 (
    .clk(clk), .we(accept && !wbank_q),
    .up_addr({1'b0, brk}), .up_re(in_up_re), .up_im(in_up_im),
    .lo_addr({1'b1, brk}), .lo_re(in_l_re),  .lo_im(in_l_im),
    .rd_addr(ridx_q), .rd_re(b0_re), .rd_im(b0_im)
  );

  fft_reorder_bank #(.WIDTH(WIDTH)) u_bank1 (
    .clk(clk), .we(accept && wbank_q),
    .up_addr({1'b0, brk}), .up_re(in_up_re), .up_im(in_up_im),
    .lo_addr({1'b1, brk}), .lo_re(in_l_re),  .lo_im(in_l_im),
    .rd_addr(ridx_q), .rd_re(b1_re), .rd_im(b1_im)
  );

  // Write-side beat counting, bank flags and read-side output register.
  always_comb begin
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    full_d      = full_q;
    k_d         = k_q;
    ridx_d      = ridx_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    frame_err_d = frame_err_q | realign;

    if (accept) begin
      k_d = keff + 4'd1;
      if (last_beat) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    // The bank being written is never the full bank being drained, so the
    // set above and the clear below never touch the same flag.
    if (load) begin
      out_valid_d = 1'b1;
      out_re_d    = rd_re;
      out_im_d    = rd_im;
      out_index_d = ridx_q;
      out_last_d  = (ridx_q == 5'(N - 1));
      ridx_d      = ridx_q + 5'd1;
      if (ridx_q == 5'(N - 1)) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      full_q      <= 2'b00;
      k_q         <= 4'd0;
      ridx_q      <= 5'd0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_index_q <= 5'd0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      full_q      <= full_d;
      k_q         <= k_d;
      ridx_q      <= ridx_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

`ifdef FFT_OUT_REORDER_SOP_EN
  assign frame_err = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: frames of random spectra are driven
// in bit-reversed beat order; the expected natural-order stream is queued
// when a frame completes and a negedge monitor pops and compares.
module tb_fft_out_reorder;

  localparam int W = 9;
  typedef logic [W-1:0] vec_t [32];
  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_up_re = '0, in_up_im = '0, in_l_re = '0, in_l_im = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_re, out_im;
  logic [4:0]   out_index;
  logic         out_last;
`ifdef FFT_OUT_REORDER_SOP_EN
  logic         in_sop = 1'b0;
  logic         frame_err;
`endif

  always #5 clk = ~clk;

  fft_out_reorder #(.WIDTH(W), .N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_up_re(in_up_re), .in_up_im(in_up_im),
    .in_l_re(in_l_re), .in_l_im(in_l_im),
`ifdef FFT_OUT_REORDER_SOP_EN
    .in_sop(in_sop), .frame_err(frame_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   beats_acc = 0;
  int   ready_low_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   mark = 1'b0;
  bit   stop_rand = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++)
      if (((k >> b) & 1) == 1) r = r + (1 << (3 - b));
    return r;
  endfunction

  // Monitor: handshake compare against the scoreboard, and stall hold check.
  logic         hold_v = 1'b0;
  logic [24:0]  hold_snap;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (in_valid && !in_ready) ready_low_cnt++;
      if (hold_v)
        chk("hold_stable", {7'd0, out_valid, out_re, out_im, out_index, out_last},
            {7'd0, hold_snap});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got index %0d expected no output", out_index);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_index", 32'(out_index), 32'(e.idx));
          chk("out_re", 32'(out_re), 32'(e.re));
          chk("out_im", 32'(out_im), 32'(e.im));
          chk("out_last", 32'(out_last), 32'(e.idx == 31));
        end
        n_out++;
        last_cyc = cyc;
        if (mark) begin
          first_cyc = cyc;
          mark = 1'b0;
        end
      end
      hold_v    = out_valid && !out_ready;
      hold_snap = {out_valid, out_re, out_im, out_index, out_last};
    end
  end

  // Drive nb beats of a frame; queue its natural-order spectrum when complete.
  task automatic send_beats(input vec_t re, input vec_t im, input int nb, input int gap_max);
    int tmo;
    for (int k = 0; k < nb; k++) begin
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_up_re = re[brev(k)];
      in_up_im = im[brev(k)];
      in_l_re  = re[16 + brev(k)];
      in_l_im  = im[16 + brev(k)];
`ifdef FFT_OUT_REORDER_SOP_EN
      in_sop = (k == 0);
`endif
      tmo = 0;
      @(negedge clk);
      while (!in_ready) begin
        @(negedge clk);
        tmo++;
        if (tmo > 3000) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 3000 cycles");
          in_valid = 1'b0;
          return;
        end
      end
      if (nb == 16 && k == 15)
        for (int i = 0; i < 32; i++) sb.push_back('{re[i], im[i], i});
      @(posedge clk);
      beats_acc++;
      #1;
    end
    in_valid = 1'b0;
`ifdef FFT_OUT_REORDER_SOP_EN
    in_sop = 1'b0;
`endif
  endtask

  task automatic rand_frame(output vec_t re, output vec_t im);
    for (int i = 0; i < 32; i++) begin
      re[i] = W'($urandom);
      im[i] = W'($urandom);
    end
  endtask

  task automatic drain();
    int tmo = 0;
    while (sb.size() != 0 && tmo < 5000) begin
      @(posedge clk);
      tmo++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
    chk("drain_out_valid_low", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re", 32'(out_re), 32'd0);
    chk("rst_out_im", 32'(out_im), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FFT_OUT_REORDER_SOP_EN
    chk("rst_frame_err", 32'(frame_err), 32'd0);
`endif
    sb.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t fr, fi;
    int   base, tmo;

    // Power-on reset.
    #3;
    do_reset();
    out_ready = 1'b1;

    // Single deterministic frame: re = index, im = -index.
    for (int i = 0; i < 32; i++) begin
      fr[i] = W'(i);
      fi[i] = W'(-i);
    end
    mark = 1'b1;
    send_beats(fr, fi, 16, 1);
    chk("latency_x0_valid", 32'(out_valid), 32'd1);
    chk("latency_x0_index", 32'(out_index), 32'd0);
    drain();
    chk("single_no_gaps", 32'(last_cyc - first_cyc), 32'd31);

    // Back-to-back: four frames, in_valid held, out_ready held.
    ready_low_cnt = 0;
    base = n_out;
    mark = 1'b1;
    for (int f = 0; f < 4; f++) begin
      rand_frame(fr, fi);
      send_beats(fr, fi, 16, 0);
    end
    drain();
    chk("b2b_count", 32'(n_out - base), 32'd128);
    chk("b2b_no_gaps", 32'(last_cyc - first_cyc), 32'd127);
    chk("b2b_in_ready_dropped", 32'(ready_low_cnt > 0), 32'd1);

    // Output stall at index 7 for five cycles.
    rand_frame(fr, fi);
    fork
      send_beats(fr, fi, 16, 0);
      begin
        tmo = 0;
        @(posedge clk);
        #1;
        while (!(out_valid && out_index == 5'd7) && tmo < 500) begin
          @(posedge clk);
          #1;
          tmo++;
        end
        chk("stall_reached_7", 32'(out_index), 32'd7);
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_hold_index", 32'(out_index), 32'd7);
        chk("stall_hold_re", 32'(out_re), 32'(fr[7]));
        out_ready = 1'b1;
      end
    join
    drain();

    // Full backpressure: three frames with the sink stopped.
    out_ready = 1'b0;
    base = beats_acc;
    fork
      for (int f = 0; f < 3; f++) begin
        vec_t r2, i2;
        rand_frame(r2, i2);
        send_beats(r2, i2, 16, 0);
      end
      begin
        tmo = 0;
        while (beats_acc - base < 32 && tmo < 500) begin
          @(posedge clk);
          tmo++;
        end
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (30) @(posedge clk);
        chk("bp_third_held", 32'(beats_acc - base), 32'd32);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_accepted", 32'(beats_acc - base), 32'd48);

    // Randomised gaps on both sides.
    stop_rand = 1'b0;
    fork
      begin
        for (int f = 0; f < 5; f++) begin
          vec_t r3, i3;
          rand_frame(r3, i3);
          send_beats(r3, i3, 16, 3);
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset during output with a partial frame pending, then recover.
    rand_frame(fr, fi);
    send_beats(fr, fi, 16, 0);
    send_beats(fr, fi, 7, 0);
    #2;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    rand_frame(fr, fi);
    send_beats(fr, fi, 16, 1);
    chk("post_rst_latency", 32'(out_valid), 32'd1);
    drain();

`ifdef FFT_OUT_REORDER_SOP_EN
    // Realign: five beats of an aborted frame, then a full frame with sop.
    chk("sop_err_clear", 32'(frame_err), 32'd0);
    rand_frame(fr, fi);
    send_beats(fr, fi, 5, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("sop_no_partial_output", 32'(out_valid), 32'd0);
    rand_frame(fr, fi);
    send_beats(fr, fi, 16, 0);
    chk("sop_err_set", 32'(frame_err), 32'd1);
    drain();
    rand_frame(fr, fi);
    send_beats(fr, fi, 16, 1);
    drain();
    chk("sop_err_sticky", 32'(frame_err), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
